inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter N, default 32, instruction and immediate width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port immsel  input  3  format select: R=0, I=1, S=2, B=3, J=4.
REQ-007 SHALL have port imm  input  N  signed immediate value to encode.
REQ-008 SHALL have port base  input  N  instruction template (opcode, rd, rs1, rs2, funct fields).
REQ-009 SHALL have port out_valid  output  1  encoded word valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
REQ-011 SHALL have port inst  output  N  encoded instruction.
REQ-012 SHALL have port err  output  1  immediate not encodable or immsel illegal; qualifies inst.
REQ-013 SHALL have port err_cnt  output  16  count of accepted outputs with err=1.

Function
REQ-014 SHALL start from base and overwrite only the immediate fields selected by immsel.
REQ-015 I: inst[31:20]=imm[11:0].
REQ-016 S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
REQ-017 B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
REQ-018 J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
REQ-019 R: inst=base and imm is ignored; immsel 5..7: inst=base and err=1.
REQ-020 Range check: I/S require imm[31:11] all equal; B requires imm[31:12] all equal and imm[0]=0; J requires imm[31:20] all equal and imm[0]=0; any failure sets err=1.
REQ-021 SHALL be a two-stage valid/ready pipeline: stage 1 registers the inputs, stage 2 registers inst and err.
REQ-022 Latency: 2 cycles from acceptance to out_valid when out_ready is held high; throughput 1 per cycle.
REQ-023 in_ready SHALL be high when stage 1 is empty or stage 1 can advance this cycle (stage 2 empty or draining).
REQ-024 While out_valid=1 and out_ready=0, inst, err and out_valid SHALL hold stable.
REQ-025 Simultaneous accept and drain on the same edge SHALL lose no entry and duplicate no entry.
REQ-026 err_cnt SHALL increment on each output handshake with err=1 and saturate at 0xFFFF.

Reset
REQ-027 rst SHALL asynchronously clear both stage valids, inst, err and err_cnt to 0.
REQ-028 Entries in flight at reset assertion SHALL be discarded; in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-029 With macro INST_ENCODER_RANGECHK_EN defined, REQ-020 applies.
REQ-030 Without INST_ENCODER_RANGECHK_EN, range checks are omitted: immediates are silently truncated to the field bits, err=1 only for illegal immsel, and err_cnt counts only illegal-immsel outputs.

Structure
REQ-031 SHALL take the immsel encodings R/I/S/B/J and the err_cnt width constant from the shared package riscv_pkg, so the immediate decoder uses the same encodings.
REQ-032 SHALL put field packing and range checking in one combinational sub-module, imm_pack; the pipeline and counter stay in inst_encoder.

Verification
REQ-033 I, imm=0xFFFFFFFF, base=0x00000013 -> inst=0xFFF00013, err=0, out_valid 2 cycles after accept.
REQ-034 S, imm=0x7FF, base=0x00002023 -> inst=0x7E002FA3, err=0.
REQ-035 B, imm=3 -> err=1, err_cnt 0->1. J, imm=0x800, base=0x6F -> inst=0x0010006F, err=0.
REQ-036 Back-to-back requests with out_ready low for 3 cycles -> in_ready drops once both stages are full; no data is lost; order is preserved; inst is stable while stalled.
REQ-037 rst pulsed with both stages full -> out_valid=0 and err_cnt=0 immediately; subsequent requests encode correctly.
REQ-038 Build without INST_ENCODER_RANGECHK_EN, I, imm=0x1000 -> err=0, inst[31:20]=0x000; immsel=6 -> err=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: immediate-format selects and the error counter width.
// Used by both the immediate encoder and the immediate decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_J = 3'd4
  } immsel_e;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters imm into the base template's immediate fields.
// Range checking is active only when INST_ENCODER_RANGECHK_EN is defined.
module imm_pack
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   immsel,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] base,
  output logic [N-1:0] inst,
  output logic         err
);

  // True when v[N-1:msb] are all equal, i.e. v is a sign-extension of v[msb:0].
  function automatic logic fits_signed(input logic [N-1:0] v, input int msb);
    logic signed [N-1:0] s;
    s = $signed(v) >>> msb;
    return (&s) | ~(|s);
  endfunction

  logic fits;
  logic sel_illegal;

  // NOTE: every output of a combinational block gets a default first; a missed
  // assignment on some case path would otherwise infer a latch.
  always_comb begin
    inst        = base;
    fits        = 1'b1;
    sel_illegal = 1'b0;
    case (immsel)
      IMM_R: ;
      IMM_I: begin
        inst[31:20] = imm[11:0];
        fits        = fits_signed(imm, 11);
      end
      IMM_S: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        fits        = fits_signed(imm, 11);
      end
      IMM_B: begin
        inst[31]    = imm[12];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        inst[7]     = imm[11];
        fits        = fits_signed(imm, 12) & ~imm[0];
      end
      IMM_J: begin
        inst[31]    = imm[20];
        inst[30:21] = imm[10:1];
        inst[20]    = imm[11];
        inst[19:12] = imm[19:12];
        fits        = fits_signed(imm, 20) & ~imm[0];
      end
      default: sel_illegal = 1'b1;
    endcase
  end

`ifdef INST_ENCODER_RANGECHK_EN
  assign err = sel_illegal | ~fits;
`else
  // Out-of-range immediates are silently truncated to the field bits.
  logic unused_fits;
  assign unused_fits = fits;
  assign err         = sel_illegal;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RISC-V immediate encoder with saturating error counter.
// Optional range checking of immediates via INST_ENCODER_RANGECHK_EN.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           immsel,
  input  logic [N-1:0]         imm,
  input  logic [N-1:0]         base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         inst,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 s1_valid_q, s1_valid_d;
  logic [2:0]           s1_immsel_q, s1_immsel_d;
  logic [N-1:0]         s1_imm_q, s1_imm_d;
  logic [N-1:0]         s1_base_q, s1_base_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [N-1:0]         inst_q, inst_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic         s2_ready;
  logic         accept;
  logic         advance;
  logic         drain;
  logic [N-1:0] pack_inst;
  logic         pack_err;

  imm_pack #(.N(N)) u_imm_pack (
    .immsel (s1_immsel_q),
    .imm    (s1_imm_q),
    .base   (s1_base_q),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  // Stage 1 may advance whenever stage 2 is empty or being drained this cycle.
  assign s2_ready = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_ready;
  assign accept   = in_valid & in_ready;
  assign advance  = s1_valid_q & s2_ready;
  assign drain    = s2_valid_q & out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_immsel_d = s1_immsel_q;
    s1_imm_d    = s1_imm_q;
    s1_base_d   = s1_base_q;
    s2_valid_d  = s2_valid_q;
    inst_d      = inst_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_immsel_d = immsel;
      s1_imm_d    = imm;
      s1_base_d   = base;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      s2_valid_d = 1'b1;
      inst_d     = pack_inst;
      err_d      = pack_err;
    end else if (drain) begin
      s2_valid_d = 1'b0;
    end

    if (drain && err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      inst_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      inst_q     <= inst_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // NOTE: the stage-1 payload is qualified by s1_valid_q, so it needs no reset;
  // keeping it out of the reset domain keeps it as plain enable flops.
  always_ff @(posedge clk) begin
    s1_immsel_q <= s1_immsel_d;
    s1_imm_q    <= s1_imm_d;
    s1_base_q   <= s1_base_d;
  end

  assign out_valid = s2_valid_q;
  assign inst      = inst_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed literal cases plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_inst_encoder;

`ifdef INST_ENCODER_RANGECHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immsel;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;
  logic [15:0] err_cnt;

  inst_encoder #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immsel    (immsel),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          acc;
  } exp_t;

  // Reference encoding: field scatter by format, range rules as integer bounds.
  function automatic exp_t model(input logic [2:0] sel, input logic [31:0] im, input logic [31:0] b);
    exp_t e;
    int   v;
    bit   fits;
    v      = $signed(im);
    fits   = 1'b1;
    e.inst = b;
    e.err  = 1'b0;
    e.acc  = 0;
    case (sel)
      3'd0: ;
      3'd1: begin
        e.inst = {im[11:0], b[19:0]};
        fits   = (v >= -2048) && (v <= 2047);
      end
      3'd2: begin
        e.inst = {im[11:5], b[24:12], im[4:0], b[6:0]};
        fits   = (v >= -2048) && (v <= 2047);
      end
      3'd3: begin
        e.inst = {im[12], im[10:5], b[24:12], im[4:1], im[11], b[6:0]};
        fits   = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      end
      3'd4: begin
        e.inst = {im[20], im[10:1], im[11], im[19:12], b[11:0]};
        fits   = (v >= -(1 << 20)) && (v < (1 << 20)) && (v % 2 == 0);
      end
      default: e.err = 1'b1;
    endcase
    if (RCHK && !fits) e.err = 1'b1;
    return e;
  endfunction

  exp_t        q[$];
  int          mcnt = 0;
  int          cyc  = 0;
  bit          hold = 1'b0;
  logic [31:0] prev_inst;
  logic        prev_err;

  always @(posedge rst) begin
    q.delete();
    mcnt = 0;
    hold = 1'b0;
  end

  // Compare process: samples 1 time unit after each falling edge.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      exp_t e;
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      check("out_valid", out_valid, (q.size() > 0) && (q[0].acc + 2 <= cyc));
      check("err_cnt", err_cnt, mcnt);
      if (hold && out_valid) begin
        check("stall_inst", inst, prev_inst);
        check("stall_err", err, prev_err);
      end
      if (out_valid && q.size() > 0) begin
        check("inst", inst, q[0].inst);
        check("err", err, q[0].err);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        if (q[0].err && mcnt != 16'hFFFF) mcnt++;
        void'(q.pop_front());
      end
      hold      = out_valid && !out_ready;
      prev_inst = inst;
      prev_err  = err;
      if (in_valid && in_ready) begin
        e     = model(immsel, imm, base);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
    int budget;
    budget   = 50;
    immsel   = s;
    imm      = i;
    base     = b;
    in_valid = 1'b1;
    while (budget > 0) begin
      #2;
      if (in_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Single request into an empty pipe with literal expectations and latency check.
  task automatic send_one(input string name, input logic [2:0] s, input logic [31:0] i,
                          input logic [31:0] b, input logic [31:0] exp_inst, input logic exp_err);
    out_ready = 1'b1;
    push(s, i, b);
    #2;
    check({name, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    #2;
    check({name, "_ov"}, out_valid, 1'b1);
    check({name, "_inst"}, inst, exp_inst);
    check({name, "_err"}, err, exp_err);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [8];
    edges = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF,
              32'd4094, 32'hFFFF_F000, 32'h000F_FFFE, 32'hFFF0_0000};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       return {{11{1'b0}}, 21'($urandom)} ^ {32{$urandom_range(0, 1) == 1}};
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    immsel    = 3'd0;
    imm       = '0;
    base      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    send_one("I_neg1", 3'd1, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    send_one("S_7ff", 3'd2, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 1'b0);
    send_one("B_odd", 3'd3, 32'd3, 32'h0000_0063, 32'h0000_0163, RCHK);
    send_one("J_800", 3'd4, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    send_one("R_base", 3'd0, 32'h1234_5678, 32'h00B5_0533, 32'h00B5_0533, 1'b0);
    send_one("I_1000", 3'd1, 32'h0000_1000, 32'h0000_0013, 32'h0000_0013, RCHK);
    send_one("sel6", 3'd6, 32'h0000_0004, 32'h0000_0033, 32'h0000_0033, 1'b1);
    #2;
    check("dir_err_cnt", err_cnt, RCHK ? 32'd3 : 32'd1);
    @(negedge clk);

    // Back-to-back with the consumer stalled: both stages fill, then in_ready drops.
    out_ready = 1'b0;
    push(3'd7, 32'd0, 32'h0000_0033);
    push(3'd1, 32'd5, 32'h0000_0013);
    immsel   = 3'd2;
    imm      = 32'hFFFF_FFF0;
    base     = 32'h0000_2023;
    in_valid = 1'b1;
    repeat (3) begin
      #2;
      check("stall_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    push(3'd2, 32'hFFFF_FFF0, 32'h0000_2023);
    repeat (4) @(negedge clk);

    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      immsel    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      imm       = rand_imm();
      base      = $urandom;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drained", q.size(), 0);

    // Reset with both stages occupied and a nonzero error count.
    out_ready = 1'b0;
    push(3'd5, 32'd0, 32'h0000_0033);
    push(3'd4, 32'd8, 32'h0000_006F);
    #2;
    check("pre_rst_ov", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_ov", out_valid, 1'b0);
    check("rst_async_cnt", err_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_ov", out_valid, 1'b0);
    @(negedge clk);
    send_one("post_rst_J", 3'd4, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
